// File: rtl/mips_run_ctrl.sv
// Run-control sequencer: streams a program image into memory, holds the core through a flush window,
// then counts RUN cycles until the core halts or the timeout expires. Writes are combinational on valid & ready.
module mips_run_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cmd_load,
  input  logic [ADDR_W:0]   load_len,
  input  logic              cmd_run,
  input  logic              prog_valid,
  input  logic [31:0]       prog_data,
  output logic              prog_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              core_halted,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              err,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT must fit in 1..2^CNT_W-1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_rem;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_timeout;
  logic                r_err;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [ADDR_W:0]     w_rem_nxt;
  logic [HOLD_W-1:0]   w_hold_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_done_nxt;
  logic                w_timeout_nxt;
  logic                w_err_nxt;
  logic                w_prog_ready;
  logic                w_core_hold;
  logic                w_beat;
  logic                w_len_ok;
  logic [CNT_W-1:0]    w_cnt_inc;

  assign w_len_ok  = (load_len != '0) && (load_len <= MAX_LEN);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_rem_nxt      = r_rem;
    w_hold_cnt_nxt = r_hold_cnt;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = r_done;
    w_timeout_nxt  = r_timeout;
    w_err_nxt      = r_err;
    w_prog_ready   = 1'b0;
    w_core_hold    = 1'b1;
    w_beat         = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Load takes priority; a simultaneous run request is dropped.
        if (cmd_load) begin
          if (w_len_ok) begin
            w_done_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
            w_err_nxt     = 1'b0;
            w_ptr_nxt     = '0;
            w_rem_nxt     = load_len;
            w_state_nxt   = S_LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (cmd_run) begin
          w_done_nxt     = 1'b0;
          w_timeout_nxt  = 1'b0;
          w_err_nxt      = 1'b0;
          w_cnt_nxt      = '0;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = S_HOLD;
        end
      end

      S_LOAD: begin
        w_prog_ready = 1'b1;
        w_beat       = prog_valid;
        if (prog_valid) begin
          w_rem_nxt = r_rem - LEN_ONE;
          // The pointer stops on the last address so a full-depth image never wraps it.
          if (r_rem == LEN_ONE) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_ptr_nxt = r_ptr + ADDR_W'(1);
          end
        end
      end

      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end

      S_RUN: begin
        w_core_hold = 1'b0;
        w_cnt_nxt   = w_cnt_inc;
        if (core_halted) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_cnt_inc == TIMEOUT_C) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_hold_cnt <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rem      <= w_rem_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign prog_ready  = w_prog_ready;
  assign mem_we      = w_beat;
  assign mem_addr    = (r_state == S_LOAD) ? r_ptr : '0;
  assign mem_wdata   = (r_state == S_LOAD) ? prog_data : '0;
  assign core_hold   = w_core_hold;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign err         = r_err;
  assign cycle_count = r_cnt;

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Run-control sequencer for the pipelined MIPS32 core. It streams a program image into instruction/data memory over a valid/ready channel. It then holds the core in reset for a fixed flush window and releases it. While the core runs, it counts cycles until the core raises HALTED or a timeout expires. It replaces hand-written memory preload and PC/HALTED/TAKEN_BRANCH initialisation in benches and system tops.

Parameters:
ADDR_W, 10, memory word-address width; maximum program length is 2^ADDR_W words.
CNT_W, 16, width of cycle counter.
TIMEOUT, 1000, maximum RUN cycles before abort; range 1..2^CNT_W-1.
HOLD_CYCLES, 2, cycles core_hold stays high after a run command, to flush the pipeline; minimum 1.

Ports:
clk1  in  1  single controller clock, rising-edge.
rst  in  1  synchronous, active-high reset.
cmd_load  in  1  one-cycle pulse: start a load session; sampled in IDLE only.
load_len  in  ADDR_W+1  number of words to load, sampled with cmd_load; valid range 1..2^ADDR_W.
cmd_run  in  1  one-cycle pulse: start execution; sampled in IDLE only.
prog_valid  in  1  program word available.
prog_data  in  32  program word.
prog_ready  out  1  controller accepts a word this cycle.
mem_we  out  1  memory write strobe.
mem_addr  out  ADDR_W  memory write word address.
mem_wdata  out  32  memory write data.
core_halted  in  1  HALTED flag from the core.
core_hold  out  1  core held: PC=0, HALTED=0, TAKEN_BRANCH=0 while high.
busy  out  1  state is not IDLE.
done  out  1  sticky: last run ended by HALTED.
timeout  out  1  sticky: last run ended by timeout.
err  out  1  sticky: last cmd_load had load_len=0 or load_len>2^ADDR_W.
cycle_count  out  CNT_W  RUN cycles of the current or last run.

Behaviour:
- States: IDLE, LOAD, HOLD, RUN.
- Reset (and rst in any state) sets:
  - state=IDLE, core_hold=1, prog_ready=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - busy=0, done=0, timeout=0, err=0, cycle_count=0;
  - internal address pointer=0, remaining count=0, hold counter=0.
- rst mid-LOAD aborts the load; words already written stay in memory. rst mid-RUN re-asserts core_hold on the next edge.
- IDLE: core_hold=1, prog_ready=0.
  - cmd_load with legal load_len: clear done/timeout/err, pointer=0, remaining=load_len, go to LOAD.
  - cmd_load with illegal load_len: err=1, stay in IDLE.
  - cmd_run: clear done/timeout/err, cycle_count=0, hold counter=0, go to HOLD.
  - cmd_load and cmd_run in the same cycle: load wins, run is dropped.
- Commands in any state other than IDLE are ignored.
- LOAD: prog_ready=1.
  - mem_we = prog_valid & prog_ready (combinational); mem_addr=pointer; mem_wdata=prog_data.
  - On each accepted beat: pointer+1, remaining-1.
  - When the beat with remaining==1 is accepted, go to IDLE; prog_ready is 0 from the next cycle.
  - Pointer never wraps; the last address is load_len-1.
  - Idle cycles (prog_valid=0) produce no write and no pointer change.
- HOLD: core_hold=1 for exactly HOLD_CYCLES cycles, then go to RUN.
- RUN: core_hold=0. Each RUN cycle, cycle_count increments by 1.
  - If core_halted=1 in that cycle: done=1, go to IDLE, cycle_count keeps the incremented value. Halt seen in the Nth RUN cycle gives cycle_count=N.
  - Else if the incremented value equals TIMEOUT: timeout=1, go to IDLE, cycle_count=TIMEOUT.
  - Halt and timeout in the same cycle: halt wins, so done=1 and timeout=0.
  - core_hold returns to 1 on the edge leaving RUN.
- core_halted is ignored outside RUN.
- done, timeout and err are cleared only by rst or by the next accepted command.

Test Plan:
1. Load: load_len=10 with words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 0ce77800, 00832800, fc000000 and prog_valid held high -> 10 consecutive mem_we pulses at addr 0..9 with matching data; prog_ready low and busy=0 after the 10th beat.
2. Backpressure: load_len=4, prog_valid pattern 1,0,0,1,1,0,1 -> exactly 4 writes at addr 0,1,2,3 on the valid cycles only; no write during gaps.
3. Run: cmd_run with HOLD_CYCLES=2, core_halted raised in the 40th RUN cycle -> core_hold high for 2 cycles then low; done=1, timeout=0, cycle_count=40, core_hold=1, busy=0.
4. Timeout: TIMEOUT=100, core_halted stays 0 -> after 100 RUN cycles timeout=1, done=0, cycle_count=100, core_hold=1; core_halted raised in cycle 100 instead -> done=1, timeout=0.
5. Commands: load_len=0 -> err=1 and state stays IDLE. cmd_load (len 2) with cmd_run in the same cycle -> LOAD only, no HOLD. cmd_run during LOAD -> ignored.
6. Reset: rst after 3 of 8 words accepted -> next cycle prog_ready=0, core_hold=1, all flags 0. A new load of len 2 writes addr 0,1.
